ram_pattern_writer: RTL and testbench
=====================================

RAM_PATTERN_WRITER -- requirements
Module: ram_pattern_writer

Interface
REQ-001 Parameter DATA_W, default 4, RAM word width.
REQ-002 Parameter ADDR_W, default 4, RAM address width; fill depth DEPTH = 2**ADDR_W.
REQ-003 clock  input  1  single system clock; all state updates on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_start  input  1  fill request; sampled only in IDLE.
REQ-006 i_abort  input  1  terminate fill; highest priority after reset.
REQ-007 i_mode  input  2  pattern select: 00 constant, 01 increment, 10 rotate-left, 11 alternate-invert.
REQ-008 i_seed  input  DATA_W  first data word of the fill.
REQ-009 i_wr_ready  input  1  RAM side accepts the current write.
REQ-010 o_wr_en  output  1  write valid toward the RAM.
REQ-011 o_wr_addr  output  ADDR_W  write address.
REQ-012 o_wr_data  output  DATA_W  write data.
REQ-013 o_busy  output  1  high in LOAD and WRITE.
REQ-014 o_done  output  1  one-cycle pulse on fill completion.
REQ-015 o_count  output  ADDR_W+1  words accepted in the current or last fill.

Function
REQ-016 States: IDLE, LOAD, WRITE, DONE; encoding is free; all outputs are registered.
REQ-017 IDLE -> LOAD when i_start=1 and i_abort=0; in IDLE, i_start is ignored if i_abort=1.
REQ-018 LOAD, one cycle: addr<=0, data<=i_seed, o_count<=0, latch i_mode; then -> WRITE.
REQ-019 WRITE: o_wr_en=1; a transfer occurs on a cycle with o_wr_en=1 and i_wr_ready=1.
REQ-020 With no transfer, o_wr_addr and o_wr_data hold stable, and o_wr_en stays high until accepted.
REQ-021 On each transfer: o_count+1, addr+1, and data updated per the latched mode: 00 unchanged; 01 +1 mod 2**DATA_W; 10 rotate left by 1; 11 bitwise invert.
REQ-022 The transfer at addr=DEPTH-1 is the last: -> DONE, o_wr_en<=0, addr wraps to 0, o_count=DEPTH.
REQ-023 DONE, one cycle: o_done=1; then -> IDLE. o_count holds until the next LOAD.
REQ-024 Back-to-back fills: i_start held high re-enters LOAD on the cycle after returning to IDLE.
REQ-025 i_abort=1 in LOAD or WRITE: -> IDLE next edge, o_wr_en<=0, no o_done, o_count holds the accepted words; a transfer on the abort cycle is still counted.
REQ-026 i_start and the i_mode/i_seed inputs are ignored while busy; mode or seed changes mid-fill have no effect.
REQ-027 Minimum fill time with i_wr_ready constantly 1: LOAD + DEPTH WRITE cycles + DONE = DEPTH+2 cycles from i_start sampled.

Reset
REQ-028 i_reset=0 asynchronously forces IDLE, with o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=0, o_done=0, o_count=0.
REQ-029 Reset asserted mid-fill discards the fill; no o_done is issued.
REQ-030 After reset release, the first start is accepted on the first rising edge with i_reset=1.

Verification
REQ-031 Start with mode=01, seed=4'hE, ready=1 -> data E,F,0,1,...,D at addr 0..15, o_done at cycle 18, o_count=16.
REQ-032 Start with mode=10, seed=4'b0001, ready toggling 1/0 -> data 1,2,4,8,1,... with addr/data stable during ready=0, o_count=16, no lost or duplicated writes.
REQ-033 Start with mode=11, seed=4'h5 -> data alternates 5,A; assert abort after 6 transfers -> IDLE, o_count=6, o_done never pulses.
REQ-034 Pull i_reset low during WRITE at addr=9 -> all outputs 0 immediately, with no clock edge needed; a new start after release begins at addr 0.
REQ-035 Hold i_start=1 continuously, mode=00, seed=4'h3 -> two consecutive fills, each 16 writes of 3, o_done pulsing once per fill, with one IDLE cycle between them.
REQ-036 Pulse i_start during WRITE and change i_seed -> no restart, and the data sequence is unaffected.

Source files
------------

// File: rtl/ram_pattern_writer_if.sv
// Bus bundle for the pattern fill engine: fill control inputs, RAM write
// handshake and status outputs. Signal names are seen from the engine's side.
interface ram_pattern_writer_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic              i_start;
  logic              i_abort;
  logic [1:0]        i_mode;
  logic [DATA_W-1:0] i_seed;
  logic              i_wr_ready;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic              o_busy;
  logic              o_done;
  logic [ADDR_W:0]   o_count;

  modport slave (
    input  i_start, i_abort, i_mode, i_seed, i_wr_ready,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_count
  );

  modport master (
    output i_start, i_abort, i_mode, i_seed, i_wr_ready,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_count
  );
endinterface

// File: rtl/ram_pattern_writer.sv
// Pattern fill engine: writes 2**ADDR_W words derived from a seed and a
// pattern mode into a RAM through a valid/ready write port.
module ram_pattern_writer #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                 clock,
  input  logic                 i_reset,
  ram_pattern_writer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt;
  logic              w_xfer;

  function automatic logic [DATA_W-1:0] f_next_word(input logic [1:0]        mode,
                                                    input logic [DATA_W-1:0] d);
    case (mode)
      2'b00:   f_next_word = d;
      2'b01:   f_next_word = d + DATA_W'(1);
      2'b10:   f_next_word = {d[DATA_W-2:0], d[DATA_W-1]};
      default: f_next_word = ~d;
    endcase
  endfunction

  assign w_xfer = r_wr_en & bus.i_wr_ready;

  // Every output is registered, so the next-state logic also computes next output values.
  always_comb begin
    w_state_nxt   = r_state;
    w_mode_nxt    = r_mode;
    w_wr_en_nxt   = r_wr_en;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_count_nxt   = r_count;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          w_state_nxt = S_LOAD;
          w_busy_nxt  = 1'b1;
        end
      end
      S_LOAD: begin
        w_wr_addr_nxt = '0;
        w_wr_data_nxt = bus.i_seed;
        w_count_nxt   = '0;
        w_mode_nxt    = bus.i_mode;
        if (bus.i_abort) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          w_state_nxt = S_WRITE;
          w_wr_en_nxt = 1'b1;
        end
      end
      S_WRITE: begin
        if (w_xfer) begin
          w_count_nxt   = r_count + (ADDR_W+1)'(1);
          w_wr_addr_nxt = r_wr_addr + ADDR_W'(1);
          w_wr_data_nxt = f_next_word(r_mode, r_wr_data);
          if (&r_wr_addr) begin
            w_state_nxt = S_DONE;
            w_wr_en_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
        // Abort still keeps a transfer that lands on the same edge, but suppresses done.
        if (bus.i_abort) begin
          w_state_nxt = S_IDLE;
          w_wr_en_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_mode    <= 2'b00;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mode    <= w_mode_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign bus.o_wr_en   = r_wr_en;
  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_count   = r_count;

endmodule

// File: tb/tb_ram_pattern_writer.sv
// Self-checking bench for ram_pattern_writer: a fill-level reference model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_ram_pattern_writer;
  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clock   = 1'b0;
  logic i_reset = 1'b1;

  ram_pattern_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram_pattern_writer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock   (clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks    = 0;
  int errors    = 0;
  int cycleNum  = 0;
  int doneCount = 0;
  int startCycle = 0;
  bit checkEn   = 1'b0;

  logic [ADDR_W-1:0] logAddr[$];
  logic [DATA_W-1:0] logData[$];
  int                doneCycles[$];

  // Fill-level model: which phase of a fill we are in and how many words went out.
  bit                mLoad    = 1'b0;
  bit                mWriting = 1'b0;
  bit                mDone    = 1'b0;
  int                mIdx     = 0;
  int                mCount   = 0;
  logic [DATA_W-1:0] mSeed    = '0;
  logic [1:0]        mMode    = 2'b00;

  // Word k of a fill, written directly as a closed form of seed and k.
  function automatic logic [DATA_W-1:0] patternWord(input logic [DATA_W-1:0] seed,
                                                    input logic [1:0]        mode,
                                                    input int                k);
    logic [DATA_W-1:0] r;
    int s;
    case (mode)
      2'b00: r = seed;
      2'b01: r = seed + DATA_W'(k);
      2'b10: begin
        s = k % DATA_W;
        r = (seed << s) | (seed >> (DATA_W - s));
      end
      default: r = (k % 2 == 1) ? ~seed : seed;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit start, input bit abort, input logic [1:0] mode,
                               input logic [DATA_W-1:0] seed, input bit ready);
    bus.i_start    = start;
    bus.i_abort    = abort;
    bus.i_mode     = mode;
    bus.i_seed     = seed;
    bus.i_wr_ready = ready;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearLog();
    logAddr.delete();
    logData.delete();
    doneCycles.delete();
    doneCount = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_wr_en"}, 32'(bus.o_wr_en), 32'd0);
    checkOutput({tag, "_addr"},  32'(bus.o_wr_addr), 32'd0);
    checkOutput({tag, "_data"},  32'(bus.o_wr_data), 32'd0);
    checkOutput({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    checkOutput({tag, "_done"},  32'(bus.o_done), 32'd0);
    checkOutput({tag, "_count"}, 32'(bus.o_count), 32'd0);
  endtask

  always @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      mLoad    <= 1'b0;
      mWriting <= 1'b0;
      mDone    <= 1'b0;
      mIdx     <= 0;
      mCount   <= 0;
    end else if (mLoad) begin
      mLoad    <= 1'b0;
      mSeed    <= bus.i_seed;
      mMode    <= bus.i_mode;
      mIdx     <= 0;
      mCount   <= 0;
      mWriting <= !bus.i_abort;
    end else if (mWriting) begin
      if (bus.i_wr_ready) begin
        mIdx   <= mIdx + 1;
        mCount <= mCount + 1;
      end
      if (bus.i_abort) begin
        mWriting <= 1'b0;
      end else if (bus.i_wr_ready && mIdx == DEPTH - 1) begin
        mWriting <= 1'b0;
        mDone    <= 1'b1;
      end
    end else if (mDone) begin
      mDone <= 1'b0;
    end else if (bus.i_start && !bus.i_abort) begin
      mLoad <= 1'b1;
    end
  end

  always @(negedge clock) begin
    cycleNum++;
    if (checkEn) begin
      checkOutput("busy",  32'(bus.o_busy),  32'(mLoad || mWriting));
      checkOutput("wr_en", 32'(bus.o_wr_en), 32'(mWriting));
      checkOutput("done",  32'(bus.o_done),  32'(mDone));
      checkOutput("count", 32'(bus.o_count), 32'(mCount));
      if (mWriting) begin
        checkOutput("addr", 32'(bus.o_wr_addr), 32'(mIdx % DEPTH));
        checkOutput("data", 32'(bus.o_wr_data), 32'(patternWord(mSeed, mMode, mIdx)));
      end
      if (!i_reset) begin
        checkOutput("rstAddr", 32'(bus.o_wr_addr), 32'd0);
        checkOutput("rstData", 32'(bus.o_wr_data), 32'd0);
      end
    end
    if (bus.o_wr_en === 1'b1 && bus.i_wr_ready === 1'b1) begin
      logAddr.push_back(bus.o_wr_addr);
      logData.push_back(bus.o_wr_data);
    end
    if (bus.o_done === 1'b1) begin
      doneCount++;
      doneCycles.push_back(cycleNum);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit aborted;
    bit found;
    applyStimulus(1'b0, 1'b0, 2'b00, 4'h0, 1'b1);
    #1 i_reset = 1'b0;
    checkEn = 1'b1;
    tick();
    tick();
    checkResetOutputs("reset");
    i_reset = 1'b1;

    $display("[TB] start ignored while abort held in idle");
    applyStimulus(1'b1, 1'b1, 2'b01, 4'h7, 1'b1);
    repeat (3) tick();
    checkOutput("idleAbortBusy", 32'(bus.o_busy), 32'd0);

    $display("[TB] increment fill from seed E");
    clearLog();
    applyStimulus(1'b1, 1'b0, 2'b01, 4'hE, 1'b1);
    startCycle = cycleNum + 1;
    tick();
    bus.i_start = 1'b0;
    repeat (20) tick();
    checkOutput("incWords",  32'(logData.size()), 32'd16);
    checkOutput("incD0",     32'(logData[0]), 32'hE);
    checkOutput("incD1",     32'(logData[1]), 32'hF);
    checkOutput("incD2",     32'(logData[2]), 32'h0);
    checkOutput("incD15",    32'(logData[15]), 32'hD);
    checkOutput("incA15",    32'(logAddr[15]), 32'd15);
    checkOutput("incCount",  32'(bus.o_count), 32'd16);
    checkOutput("incDones",  32'(doneCount), 32'd1);
    checkOutput("incDoneAt", 32'(doneCycles[0] - startCycle), 32'd18);

    $display("[TB] rotate fill with ready toggling");
    clearLog();
    applyStimulus(1'b1, 1'b0, 2'b10, 4'b0001, 1'b1);
    tick();
    bus.i_start = 1'b0;
    for (int i = 0; i < 45; i++) begin
      bus.i_wr_ready = (i % 2 == 0);
      tick();
    end
    bus.i_wr_ready = 1'b1;
    checkOutput("rotWords", 32'(logData.size()), 32'd16);
    checkOutput("rotD0",    32'(logData[0]), 32'h1);
    checkOutput("rotD1",    32'(logData[1]), 32'h2);
    checkOutput("rotD2",    32'(logData[2]), 32'h4);
    checkOutput("rotD3",    32'(logData[3]), 32'h8);
    checkOutput("rotD4",    32'(logData[4]), 32'h1);
    checkOutput("rotA15",   32'(logAddr[15]), 32'd15);
    checkOutput("rotCount", 32'(bus.o_count), 32'd16);
    checkOutput("rotDones", 32'(doneCount), 32'd1);

    $display("[TB] invert fill aborted on the sixth transfer");
    clearLog();
    applyStimulus(1'b1, 1'b0, 2'b11, 4'h5, 1'b1);
    tick();
    bus.i_start = 1'b0;
    aborted = 1'b0;
    for (int i = 0; i < 30 && !aborted; i++) begin
      if (logData.size() == 5) begin
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        aborted = 1'b1;
      end else begin
        tick();
      end
    end
    repeat (5) tick();
    checkOutput("abortReached", 32'(aborted), 32'd1);
    checkOutput("abortWords",   32'(logData.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      checkOutput("abortData", 32'(logData[k]), (k % 2 == 0) ? 32'h5 : 32'hA);
    checkOutput("abortCount", 32'(bus.o_count), 32'd6);
    checkOutput("abortBusy",  32'(bus.o_busy), 32'd0);
    checkOutput("abortWrEn",  32'(bus.o_wr_en), 32'd0);
    checkOutput("abortDones", 32'(doneCount), 32'd0);

    $display("[TB] asynchronous reset in the middle of a fill");
    clearLog();
    applyStimulus(1'b1, 1'b0, 2'b01, 4'h0, 1'b1);
    tick();
    bus.i_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (bus.o_wr_en === 1'b1 && bus.o_wr_addr == 4'd9) found = 1'b1;
    end
    checkOutput("rstAddr9Reached", 32'(found), 32'd1);
    #2 i_reset = 1'b0;
    #1 checkResetOutputs("midReset");
    repeat (2) tick();
    checkOutput("rstNoDone", 32'(doneCount), 32'd0);
    clearLog();
    i_reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'b01, 4'hA, 1'b1);
    tick();
    bus.i_start = 1'b0;
    repeat (20) tick();
    checkOutput("postRstWords", 32'(logData.size()), 32'd16);
    checkOutput("postRstA0",    32'(logAddr[0]), 32'd0);
    checkOutput("postRstD0",    32'(logData[0]), 32'hA);
    checkOutput("postRstD15",   32'(logData[15]), 32'h9);
    checkOutput("postRstDones", 32'(doneCount), 32'd1);

    $display("[TB] start held high for back-to-back constant fills");
    clearLog();
    applyStimulus(1'b1, 1'b0, 2'b00, 4'h3, 1'b1);
    repeat (30) tick();
    bus.i_start = 1'b0;
    repeat (25) tick();
    checkOutput("b2bWords", 32'(logData.size()), 32'd32);
    for (int k = 0; k < 32; k++)
      checkOutput("b2bData", 32'(logData[k]), 32'h3);
    checkOutput("b2bDones", 32'(doneCount), 32'd2);
    checkOutput("b2bGap",   32'(doneCycles[1] - doneCycles[0]), 32'd19);

    $display("[TB] start and seed changes during a fill are ignored");
    clearLog();
    applyStimulus(1'b1, 1'b0, 2'b01, 4'h2, 1'b1);
    tick();
    bus.i_start = 1'b0;
    repeat (5) tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 4'hF, 1'b1);
    repeat (3) tick();
    bus.i_start = 1'b0;
    repeat (15) tick();
    checkOutput("busyWords", 32'(logData.size()), 32'd16);
    checkOutput("busyD0",    32'(logData[0]), 32'h2);
    checkOutput("busyD5",    32'(logData[5]), 32'h7);
    checkOutput("busyD15",   32'(logData[15]), 32'h1);
    checkOutput("busyDones", 32'(doneCount), 32'd1);
    checkOutput("busyIdle",  32'(bus.o_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
